stream_fork_using_fifos: RTL and testbench
==========================================

// Module: stream_fork_using_fifos
//
// PURPOSE
// Splits one valid/ready input stream into two independent valid/ready output
// streams (branch "a" and branch "b"). Every accepted input word is delivered
// once on each branch, in order. Each branch has its own FIFO, so one slow
// consumer does not stall the other until that consumer's FIFO fills.
// This is the fork counterpart of the two-FIFO a+b join.
//
// PARAMETERS
// width  4  data width of in_data, a_data and b_data, in bits
// depth  4  entries per branch FIFO; must be a power of two and >= 2
//
// PORTS
// clk      input   1      clock; all state updates on the rising edge
// rst      input   1      asynchronous reset, ACTIVE-LOW (0 = in reset)
// in_valid input   1      upstream word present
// in_ready output  1      fork can accept a word this cycle
// in_data  input   width  upstream word
// a_valid  output  1      branch a has a word
// a_ready  input   1      branch a consumer accepts
// a_data   output  width  branch a word (head of FIFO a)
// b_valid  output  1      branch b has a word
// b_ready  input   1      branch b consumer accepts
// b_data   output  width  branch b word (head of FIFO b)
//
// BEHAVIOUR
// - Reset: rst=0 asynchronously empties both FIFOs (pointers and counters
//   cleared). While rst=0: in_ready=0, a_valid=0, b_valid=0. a_data/b_data
//   are don't-care whenever the matching valid is 0. Memory is not reset.
// - in_ready = ~full_a & ~full_b, taken from registered state only. There is
//   no combinational path from a_ready/b_ready to in_ready.
// - Push: in_valid & in_ready -> the word is written into both FIFOs on the
//   same edge. A push is never partial: it goes to both FIFOs or to neither.
// - a_valid = ~empty_a; pop a on a_valid & a_ready. Branch b is identical.
//   Each branch pops independently.
// - Latency: a word accepted on edge N is first visible on a_data/b_data in
//   the cycle after N. There is no bypass. Throughput is 1 word/cycle/branch.
// - Full/empty: per FIFO, read/write pointers of $clog2(depth)+1 bits.
//   The MSB is the wrap bit.
//   - empty: pointers equal.
//   - full: low bits equal and MSBs differ.
//   - Pointers wrap modulo 2*depth; order is preserved across the wrap.
// - Pop and push on the same edge:
//   - Empty FIFO: only the push takes effect (valid was 0, so no pop).
//     The FIFO holds 1 word afterwards.
//   - Full FIFO: in_ready was already 0, so only the pop happens. in_ready
//     rises the next cycle. A push cannot land in the slot freed that cycle.
//   - Otherwise: occupancy is unchanged.
// - Without a reset in between, every input word appears exactly once on a
//   and exactly once on b. No word is dropped, duplicated or reordered.
// - The valid outputs are never withdrawn until the matching ready is seen.
//
// TESTING
// Every scenario checks each branch against its own queue-based scoreboard.
// 1. Back-to-back: after reset, in_valid=1, in_data=1,2,3..., a/b_ready=1
//    -> a_data and b_data show 1,2,3... one per cycle, starting 1 cycle
//    after the first accept; in_ready stays 1.
// 2. Slow branch: a_ready=0, b_ready=1, push 5,6,7,8 (depth=4)
//    -> b drains 5..8; a_valid=1 with a_data=5; in_ready=0 after the 4th
//    accept; set a_ready=1 -> a gives 5..8; in_ready=1 the cycle after
//    the first a pop.
// 3. Full backpressure: a/b_ready=0, in_valid=1 -> exactly 4 accepts, then
//    in_ready=0; pop a once while in_valid=1 -> no accept that cycle, and
//    the accept happens the next cycle only if FIFO b is also not full.
// 4. Wrap-around: push 0..15 with a_ready toggling 1,0,1,0 and b_ready=1
//    -> both branches output 0..15 in order; no overflow and no underflow.
// 5. Reset mid-flight: 3 words queued per branch, drive rst=0 between
//    edges -> a_valid, b_valid and in_ready go 0 immediately; after
//    rst=1, both FIFOs are empty and no stale word ever appears.
// 6. Random: 100 transfers with random in_valid, a_ready and b_ready
//    -> a count = b count = in count = 100; both scoreboards are empty
//    at the end.

Source files
------------

// File: rtl/stream_fork_using_fifos.sv
// stream_fork_using_fifos
//
// Purpose: splits one valid/ready stream into two independent valid/ready
// streams (a and b). Each accepted input word is written into a private FIFO
// per branch on the same edge, so each branch drains at its own pace and the
// input only stalls once either FIFO is full.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active-low
//   in_valid/in_ready   upstream handshake, in_data upstream word
//   a_valid/a_ready     branch a handshake, a_data head of FIFO a
//   b_valid/b_ready     branch b handshake, b_data head of FIFO b

// Single FIFO used for each branch. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without an occupancy counter.
module stream_fork_fifo #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wr_data,
    output logic [width-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] ptr_one = (aw+1)'(1);

    logic [aw:0]      wr_ptr;
    logic [aw:0]      rd_ptr;
    logic [width-1:0] mem [depth];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[aw] != rd_ptr[aw]) &&
                     (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign rd_data = mem[rd_ptr[aw-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    // Storage is deliberately not reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[aw-1:0]] <= wr_data;
    end
endmodule

module stream_fork_using_fifos #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [width-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [width-1:0] b_data
);
    logic full_a, empty_a, full_b, empty_b;
    logic push, pop_a, pop_b;

    // in_ready depends only on registered FIFO state (plus reset), never on
    // the branch readies, so a pop cannot free a slot for a push that cycle.
    assign in_ready = rst & ~full_a & ~full_b;
    assign a_valid  = rst & ~empty_a;
    assign b_valid  = rst & ~empty_b;

    // One push term feeds both FIFOs so a word is never written to only one.
    assign push  = in_valid & in_ready;
    assign pop_a = a_valid & a_ready;
    assign pop_b = b_valid & b_ready;

    stream_fork_fifo #(.width(width), .depth(depth)) u_fifo_a (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop_a),
        .wr_data (in_data),
        .rd_data (a_data),
        .full    (full_a),
        .empty   (empty_a)
    );

    stream_fork_fifo #(.width(width), .depth(depth)) u_fifo_b (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop_b),
        .wr_data (in_data),
        .rd_data (b_data),
        .full    (full_b),
        .empty   (empty_b)
    );
endmodule

// File: tb/tb_stream_fork_using_fifos.sv
module tb_stream_fork_using_fifos;
    localparam int width = 4;
    localparam int depth = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [width-1:0] in_data;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [width-1:0] a_data, b_data;

    int checks = 0;
    int errors = 0;

    logic [width-1:0] qa[$];
    logic [width-1:0] qb[$];
    logic [width-1:0] got_a[$];
    logic [width-1:0] got_b[$];
    bit log_en = 1'b0;
    int in_cnt = 0, a_cnt = 0, b_cnt = 0;

    always #5 clk = ~clk;

    stream_fork_using_fifos #(.width(width), .depth(depth)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two plain queues. At each falling edge the outputs are
    // compared against the queues, then the transfers the next rising edge
    // will perform are applied to the queues.
    always @(negedge clk) begin
        bit exp_ir, pa, pb, pu;
        if (!rst) begin
            qa.delete();
            qb.delete();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_a_valid", a_valid, 0);
            chk("rst_b_valid", b_valid, 0);
        end else begin
            exp_ir = (qa.size() < depth) && (qb.size() < depth);
            chk("m_in_ready", in_ready, exp_ir);
            chk("m_a_valid", a_valid, qa.size() != 0);
            chk("m_b_valid", b_valid, qb.size() != 0);
            if (qa.size() != 0) chk("m_a_data", a_data, qa[0]);
            if (qb.size() != 0) chk("m_b_data", b_data, qb[0]);
            pa = (qa.size() != 0) && a_ready;
            pb = (qb.size() != 0) && b_ready;
            pu = in_valid && exp_ir;
            if (pa) begin
                if (log_en) got_a.push_back(a_data);
                void'(qa.pop_front());
                a_cnt++;
            end
            if (pb) begin
                if (log_en) got_b.push_back(b_data);
                void'(qb.pop_front());
                b_cnt++;
            end
            if (pu) begin
                qa.push_back(in_data);
                qb.push_back(in_data);
                in_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        repeat (n) step();
        chk("drain_a_empty", a_valid, 0);
        chk("drain_b_empty", b_valid, 0);
    endtask

    initial begin
        int acc, guard, base_in, base_a, base_b;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
        repeat (2) step();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_a_valid", a_valid, 0);
        chk("reset_b_valid", b_valid, 0);
        rst = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1);

        // 1. back-to-back
        a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = width'(i);
            step();
            chk("s1_a_data", a_data, i);
            chk("s1_b_data", b_data, i);
            chk("s1_in_ready", in_ready, 1);
        end
        drain(3);

        // 2. slow branch a
        a_ready = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = width'(5 + i);
            step();
        end
        in_valid = 1'b0;
        chk("s2_in_ready_full", in_ready, 0);
        chk("s2_a_valid", a_valid, 1);
        chk("s2_a_head", a_data, 5);
        step(); step();
        chk("s2_b_drained", b_valid, 0);
        chk("s2_still_full", in_ready, 0);
        a_ready = 1'b1;
        step();
        chk("s2_in_ready_after_pop", in_ready, 1);
        chk("s2_a6", a_data, 6);
        step(); chk("s2_a7", a_data, 7);
        step(); chk("s2_a8", a_data, 8);
        step(); chk("s2_a_empty", a_valid, 0);

        // 3. full backpressure
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 7; i++) begin
            in_data = width'($urandom);
            if (in_ready) acc++;
            step();
        end
        chk("s3_accepts", acc, 4);
        chk("s3_in_ready", in_ready, 0);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        chk("s3_no_accept_b_full", in_ready, 0);
        chk("s3_a_valid", a_valid, 1);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        chk("s3_in_ready_rises", in_ready, 1);
        step();
        chk("s3_refull", in_ready, 0);
        drain(6);

        // 4. wrap-around with a toggling ready
        got_a.delete(); got_b.delete(); log_en = 1'b1;
        b_ready = 1'b1; a_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = width'(i);
            guard = 0;
            forever begin
                acc = int'(in_ready);
                step();
                a_ready = ~a_ready;
                guard++;
                if (acc != 0 || guard > 50) break;
            end
            if (guard > 50) chk("s4_accept_timeout", guard, 0);
        end
        drain(10);
        log_en = 1'b0;
        chk("s4_a_count", got_a.size(), 16);
        chk("s4_b_count", got_b.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_a.size()) chk("s4_a_order", got_a[i], i);
            if (i < got_b.size()) chk("s4_b_order", got_b[i], i);
        end

        // 5. reset mid-flight
        a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = width'(10 + i);
            step();
        end
        in_valid = 1'b0;
        chk("s5_a_queued", a_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("s5_async_in_ready", in_ready, 0);
        chk("s5_async_a_valid", a_valid, 0);
        chk("s5_async_b_valid", b_valid, 0);
        step();
        rst = 1'b1;
        #1;
        chk("s5_empty_a", a_valid, 0);
        chk("s5_empty_b", b_valid, 0);
        chk("s5_in_ready", in_ready, 1);
        a_ready = 1'b1; b_ready = 1'b1;
        repeat (3) step();
        chk("s5_no_stale_a", a_valid, 0);

        // 6. random
        base_in = in_cnt; base_a = a_cnt; base_b = b_cnt; guard = 0;
        while ((in_cnt - base_in) < 100 && guard < 5000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = width'($urandom);
            a_ready  = ($urandom_range(0, 2) != 0);
            b_ready  = ($urandom_range(0, 3) == 0);
            step();
            guard++;
        end
        if (guard >= 5000) chk("s6_timeout", guard, 0);
        drain(12);
        chk("s6_in_count", in_cnt - base_in, 100);
        chk("s6_a_count", a_cnt - base_a, 100);
        chk("s6_b_count", b_cnt - base_b, 100);
        chk("s6_qa_empty", qa.size(), 0);
        chk("s6_qb_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
